// File: rtl/bus_cycle_ctrl.sv
// Bus cycle controller: drives PC nibbles onto the data bus during A1-A3 and
// latches one- or two-word opcodes from M1/M2, pulsing instr_valid after X3.
module bus_cycle_ctrl (
  input  logic        toggle_clk,
  input  logic        rst_n,
  input  logic [2:0]  cycle,
  input  logic        sync,
  input  logic [11:0] pc,
  input  logic [3:0]  d_in,
  output logic [3:0]  d_out,
  output logic        d_oe,
  output logic        pc_inc,
  output logic        cm_rom,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic [3:0]  opr2,
  output logic [3:0]  opa2,
  output logic        two_word,
  output logic        instr_valid,
  output logic        sync_err
);

  typedef enum logic {WORD1, WORD2} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_armed;
  logic [3:0] r_opr, r_opa, r_opr2, r_opa2;
  logic       r_two_word;
  logic       r_instr_valid;
  logic       r_sync_err;

  logic       w_cap_opr, w_cap_opa, w_cap_opr2, w_cap_opa2;
  logic       w_valid_nxt;
  logic       w_two_word_nxt;
  logic       w_is_x3;

  assign w_is_x3 = (cycle == 3'd7);

  // Decided from the already-latched opr and the opa nibble arriving this edge.
  assign w_two_word_nxt = (r_opr inside {4'h1, 4'h4, 4'h5, 4'h7}) ||
                          ((r_opr == 4'h2) && !d_in[0]);

  always_comb begin
    d_oe   = (cycle < 3'd3);
    cm_rom = r_armed && (cycle == 3'd2);
    pc_inc = r_armed && (cycle == 3'd4);
    case (cycle)
      3'd0:    d_out = pc[3:0];
      3'd1:    d_out = pc[7:4];
      3'd2:    d_out = pc[11:8];
      default: d_out = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_opr   = 1'b0;
    w_cap_opa   = 1'b0;
    w_cap_opr2  = 1'b0;
    w_cap_opa2  = 1'b0;
    w_valid_nxt = 1'b0;
    if (r_armed) begin
      unique case (r_state)
        WORD1: begin
          w_cap_opr = (cycle == 3'd3);
          w_cap_opa = (cycle == 3'd4);
          if (w_is_x3) begin
            if (r_two_word) w_state_nxt = WORD2;
            else            w_valid_nxt = 1'b1;
          end
        end
        WORD2: begin
          w_cap_opr2 = (cycle == 3'd3);
          w_cap_opa2 = (cycle == 3'd4);
          if (w_is_x3) begin
            w_state_nxt = WORD1;
            w_valid_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge toggle_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WORD1;
      r_armed       <= 1'b0;
      r_opr         <= '0;
      r_opa         <= '0;
      r_opr2        <= '0;
      r_opa2        <= '0;
      r_two_word    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_instr_valid <= w_valid_nxt;
      if (cycle == 3'd0) r_armed <= 1'b1;
      if (r_armed && (sync != w_is_x3)) r_sync_err <= 1'b1;
      if (w_cap_opr) r_opr <= d_in;
      if (w_cap_opa) begin
        r_opa      <= d_in;
        r_two_word <= w_two_word_nxt;
      end
      if (w_cap_opr2) r_opr2 <= d_in;
      if (w_cap_opa2) r_opa2 <= d_in;
    end
  end

  assign opr         = r_opr;
  assign opa         = r_opa;
  assign opr2        = r_opr2;
  assign opa2        = r_opa2;
  assign two_word    = r_two_word;
  assign instr_valid = r_instr_valid;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: instruction table plus scoreboard of
// expected opcode nibbles, with hand-written reset/arming/sync sequences.
module tb_bus_cycle_ctrl;

  logic        toggle_clk;
  logic        rst_n;
  logic [2:0]  cycle;
  logic        sync;
  logic [11:0] pc;
  logic [3:0]  d_in;
  logic [3:0]  d_out;
  logic        d_oe;
  logic        pc_inc;
  logic        cm_rom;
  logic [3:0]  opr, opa, opr2, opa2;
  logic        two_word;
  logic        instr_valid;
  logic        sync_err;

  bus_cycle_ctrl dut (
    .toggle_clk  (toggle_clk),
    .rst_n       (rst_n),
    .cycle       (cycle),
    .sync        (sync),
    .pc          (pc),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .pc_inc      (pc_inc),
    .cm_rom      (cm_rom),
    .opr         (opr),
    .opa         (opa),
    .opr2        (opr2),
    .opa2        (opa2),
    .two_word    (two_word),
    .instr_valid (instr_valid),
    .sync_err    (sync_err)
  );

  initial toggle_clk = 1'b0;
  always #5 toggle_clk = ~toggle_clk;

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  opr, opa, opr2, opa2;
    logic        tw;
  } vec_t;

  typedef struct {
    logic [3:0] opr, opa, opr2, opa2;
    logic       tw;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  int   n_chk;
  int   n_fail;
  logic armed_m;
  logic exp_serr;
  logic [3:0] last_opr2, last_opa2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_dout(input logic [2:0] c, input logic [11:0] p);
    case (c)
      3'd0:    return p[3:0];
      3'd1:    return p[7:4];
      3'd2:    return p[11:8];
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    armed_m   = 1'b0;
    exp_serr  = 1'b0;
    last_opr2 = 4'h0;
    last_opa2 = 4'h0;
    sb.delete();
  endtask

  task automatic chk_regs_zero();
    chk("rst_opr", opr, 0);
    chk("rst_opa", opa, 0);
    chk("rst_opr2", opr2, 0);
    chk("rst_opa2", opa2, 0);
    chk("rst_two_word", two_word, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_sync_err", sync_err, 0);
  endtask

  // One bus cycle: combinational checks mid-cycle, registered checks after the edge.
  task automatic step(input logic [2:0] c, input logic s, input logic [3:0] d, input logic exp_iv);
    exp_t e;
    cycle = c;
    sync  = s;
    d_in  = d;
    @(negedge toggle_clk);
    chk("d_oe", d_oe, (c < 3'd3));
    chk("d_out", d_out, exp_dout(c, pc));
    chk("cm_rom", cm_rom, armed_m && (c == 3'd2));
    chk("pc_inc", pc_inc, armed_m && (c == 3'd4));
    @(posedge toggle_clk);
    if (rst_n) begin
      if (armed_m && (s != (c == 3'd7))) exp_serr = 1'b1;
      if (c == 3'd0) armed_m = 1'b1;
    end
    #1;
    chk("instr_valid", instr_valid, exp_iv);
    chk("sync_err", sync_err, exp_serr);
    if (exp_iv) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("opr", opr, e.opr);
        chk("opa", opa, e.opa);
        chk("opr2", opr2, e.opr2);
        chk("opa2", opa2, e.opa2);
        chk("two_word", two_word, e.tw);
      end
    end
  endtask

  task automatic run_instr(input vec_t v, input logic glitch);
    exp_t e;
    logic [3:0] d;
    e.opr  = v.opr;
    e.opa  = v.opa;
    e.tw   = v.tw;
    e.opr2 = v.tw ? v.opr2 : last_opr2;
    e.opa2 = v.tw ? v.opa2 : last_opa2;
    last_opr2 = e.opr2;
    last_opa2 = e.opa2;
    sb.push_back(e);
    pc = v.pc;
    for (int unsigned i = 0; i < 8; i++) begin
      d = (i == 3) ? v.opr : (i == 4) ? v.opa : 4'($urandom_range(15));
      step(3'(i), (i == 7) || (glitch && i == 3), d, (i == 7) && !v.tw);
      if (i == 4) chk("two_word_decode", two_word, v.tw);
    end
    if (v.tw) begin
      for (int unsigned i = 0; i < 8; i++) begin
        d = (i == 3) ? v.opr2 : (i == 4) ? v.opa2 : 4'($urandom_range(15));
        step(3'(i), (i == 7), d, (i == 7));
      end
    end
  endtask

  initial begin
    vecs[0]  = '{12'hABC, 4'hD, 4'h4, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{12'h123, 4'h4, 4'h1, 4'h5, 4'h6, 1'b1};
    vecs[2]  = '{12'h456, 4'h2, 4'h1, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{12'h789, 4'h2, 4'h0, 4'h3, 4'h9, 1'b1};
    vecs[4]  = '{12'hFED, 4'h1, 4'h7, 4'hA, 4'hB, 1'b1};
    vecs[5]  = '{12'h0F0, 4'h7, 4'hF, 4'hC, 4'h2, 1'b1};
    vecs[6]  = '{12'h5A5, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[7]  = '{12'hFFF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{12'h000, 4'h5, 4'h2, 4'h8, 4'h1, 1'b1};
    vecs[9]  = '{12'h369, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[10] = '{12'hC3A, 4'h2, 4'hE, 4'hE, 4'h7, 1'b1};
    vecs[11] = '{12'h81F, 4'h2, 4'hF, 4'h0, 4'h0, 1'b0};

    n_chk  = 0;
    n_fail = 0;
    model_reset();
    rst_n = 1'b1;
    cycle = 3'd0;
    sync  = 1'b0;
    pc    = 12'hABC;
    d_in  = 4'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge toggle_clk);
    #1;
    chk_regs_zero();
    step(3'd2, 1'b0, 4'h3, 1'b0);
    step(3'd4, 1'b0, 4'h4, 1'b0);
    @(negedge toggle_clk);
    rst_n = 1'b1;

    // Not yet armed: no captures, no valid, sync mismatch ignored.
    step(3'd3, 1'b1, 4'h9, 1'b0);
    step(3'd4, 1'b0, 4'h2, 1'b0);
    step(3'd5, 1'b0, 4'h1, 1'b0);
    step(3'd6, 1'b0, 4'h1, 1'b0);
    step(3'd7, 1'b1, 4'h1, 1'b0);
    chk("prearm_opr", opr, 0);
    chk("prearm_opa", opa, 0);
    chk("prearm_two_word", two_word, 0);

    for (int unsigned k = 0; k < 12; k++)
      run_instr(vecs[k], k == 5);

    // Reset in WORD2 at cycle 5 discards the partial two-word instruction.
    pc = 12'h246;
    for (int unsigned i = 0; i < 8; i++)
      step(3'(i), (i == 7), (i == 3) ? 4'h4 : (i == 4) ? 4'h1 : 4'h0, 1'b0);
    for (int unsigned i = 0; i < 5; i++)
      step(3'(i), 1'b0, (i == 3) ? 4'h5 : (i == 4) ? 4'h6 : 4'h0, 1'b0);
    cycle = 3'd5;
    #2 rst_n = 1'b0;
    #1;
    chk_regs_zero();
    model_reset();
    step(3'd6, 1'b0, 4'h0, 1'b0);
    step(3'd2, 1'b0, 4'h0, 1'b0);
    @(negedge toggle_clk);
    rst_n = 1'b1;
    step(3'd5, 1'b0, 4'h7, 1'b0);
    step(3'd6, 1'b0, 4'h7, 1'b0);
    step(3'd7, 1'b1, 4'h7, 1'b0);
    run_instr(vecs[2], 1'b0);
    run_instr(vecs[1], 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
